// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit word access over a 16-bit SRAM in two wait-stretched halfword phases
`timescale 1ns/1ps
module sram_controller #(
   parameter int WAIT_CYCLES = 2,
   parameter int SRAM_ADDR_W = 18
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mem_read_in,
   input  logic                   mem_write_in,
   input  logic [31:0]            address_in,
   input  logic [31:0]            data_in,
   output logic [31:0]            data_out,
   output logic                   ready_out,
   output logic [SRAM_ADDR_W-1:0] sram_addr_out,
   output logic [15:0]            sram_wdata_out,
   input  logic [15:0]            sram_rdata_in,
   output logic                   sram_we_n_out
);
   localparam int CNT_W = $clog2(WAIT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       cnt_inc;
   logic                   op_write;
   logic [SRAM_ADDR_W-2:0] word;
   logic [31:0]            wr_data;
   logic                   request;
   logic                   unused_addr_bits;

   assign request          = mem_read_in | mem_write_in;
   assign cnt_inc          = cnt + CNT_W'(1);
   assign ready_out        = (state == DONE) || ((state == IDLE) && !request);
   assign unused_addr_bits = ^{address_in[31:SRAM_ADDR_W+1], address_in[1:0]};

   // SRAM pins are registered for the state being entered, so they are stable for the whole phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         cnt            <= '0;
         op_write       <= 1'b0;
         word           <= '0;
         wr_data        <= '0;
         data_out       <= '0;
         sram_addr_out  <= '0;
         sram_wdata_out <= '0;
         sram_we_n_out  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (request) begin
                  state          <= LOW;
                  cnt            <= '0;
                  op_write       <= mem_write_in;
                  word           <= address_in[SRAM_ADDR_W:2];
                  wr_data        <= data_in;
                  sram_addr_out  <= {address_in[SRAM_ADDR_W:2], 1'b0};
                  sram_wdata_out <= data_in[15:0];
                  sram_we_n_out  <= ~mem_write_in;
               end
            end
            LOW: begin
               if (cnt == CNT_LAST) begin
                  if (!op_write) begin
                     data_out[15:0] <= sram_rdata_in;
                  end
                  state          <= HIGH;
                  cnt            <= '0;
                  sram_addr_out  <= {word, 1'b1};
                  sram_wdata_out <= wr_data[31:16];
                  sram_we_n_out  <= ~op_write;
               end else begin
                  cnt           <= cnt_inc;
                  // release we_n one cycle early so address/data are held past the strobe
                  sram_we_n_out <= ~op_write | (cnt_inc == CNT_LAST);
               end
            end
            HIGH: begin
               if (cnt == CNT_LAST) begin
                  if (!op_write) begin
                     data_out[31:16] <= sram_rdata_in;
                  end
                  state         <= DONE;
                  cnt           <= '0;
                  sram_we_n_out <= 1'b1;
               end else begin
                  cnt           <= cnt_inc;
                  sram_we_n_out <= ~op_write | (cnt_inc == CNT_LAST);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - randomized and directed checks of sram_controller against a transaction-level model
`timescale 1ns/1ps
module tb_sram_controller;
   localparam int W  = 2;
   localparam int W3 = 3;
   localparam int AW = 18;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          mem_clr;
   logic          rd, wr;
   logic [31:0]   addr, din, dout;
   logic          ready;
   logic [AW-1:0] saddr;
   logic [15:0]   swdata, srdata;
   logic          we_n;

   logic          rd3, wr3;
   logic [31:0]   addr3, din3, dout3;
   logic          ready3;
   logic [AW-1:0] saddr3;
   logic [15:0]   swdata3, srdata3;
   logic          we_n3;

   sram_controller #(.WAIT_CYCLES(W), .SRAM_ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .mem_read_in(rd), .mem_write_in(wr),
      .address_in(addr), .data_in(din), .data_out(dout), .ready_out(ready),
      .sram_addr_out(saddr), .sram_wdata_out(swdata), .sram_rdata_in(srdata),
      .sram_we_n_out(we_n)
   );

   sram_controller #(.WAIT_CYCLES(W3), .SRAM_ADDR_W(AW)) dut3 (
      .clk(clk), .rst(rst), .mem_read_in(rd3), .mem_write_in(wr3),
      .address_in(addr3), .data_in(din3), .data_out(dout3), .ready_out(ready3),
      .sram_addr_out(saddr3), .sram_wdata_out(swdata3), .sram_rdata_in(srdata3),
      .sram_we_n_out(we_n3)
   );

   // SRAM models: a write lands on any clock edge that sees we_n low
   logic [15:0] smem  [0:63];
   logic [15:0] smem3 [0:63];
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 64; i++) begin
            smem[i]  <= 16'h0;
            smem3[i] <= 16'h0;
         end
      end else begin
         if (!we_n)  smem[saddr[5:0]]   <= swdata;
         if (!we_n3) smem3[saddr3[5:0]] <= swdata3;
      end
   end
   assign srdata  = smem[saddr[5:0]];
   assign srdata3 = smem3[saddr3[5:0]];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: cycle k of an access (0 = request seen in idle) fixes every output.
   bit            chk_en = 1'b0;
   bit            m_busy = 1'b0;
   int            m_k    = 0;
   bit            m_wr;
   logic [AW-2:0] m_word;
   logic [31:0]   m_data;
   logic [31:0]   exp_dout = '0;
   logic [31:0]   gmem [int];
   logic          m_hi;
   int            m_c;
   logic [31:0]   m_tmp;

   function automatic logic [31:0] gread(input logic [AW-2:0] w);
      if (gmem.exists(int'(w))) return gmem[int'(w)];
      return '0;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         if (m_busy) m_k = m_k + 1;
         if (!m_busy) begin
            chk("ready_idle", 32'(ready), 32'(!(rd || wr)));
            chk("we_n_idle", 32'(we_n), 32'd1);
            chk("dout_idle", dout, exp_dout);
            if ((rd || wr) && !rst) begin
               m_busy = 1'b1;
               m_k    = 0;
               m_wr   = wr;
               m_word = addr[AW:2];
               m_data = din;
            end
         end else if (m_k <= 2*W) begin
            m_hi = (m_k > W);
            m_c  = (m_k - 1) % W;
            if (m_k == W + 1 && !m_wr) begin
               m_tmp = gread(m_word);
               exp_dout[15:0] = m_tmp[15:0];
            end
            chk("ready_busy", 32'(ready), 32'd0);
            chk("addr", 32'(saddr), 32'({m_word, m_hi}));
            chk("wdata", 32'(swdata), 32'(m_hi ? m_data[31:16] : m_data[15:0]));
            chk("we_n", 32'(we_n), 32'(!(m_wr && m_c != W - 1)));
            chk("dout_busy", dout, exp_dout);
         end else begin
            if (m_wr) begin
               gmem[int'(m_word)] = m_data;
            end else begin
               m_tmp = gread(m_word);
               exp_dout[31:16] = m_tmp[31:16];
            end
            chk("ready_done", 32'(ready), 32'd1);
            chk("we_n_done", 32'(we_n), 32'd1);
            chk("dout_done", dout, exp_dout);
            m_busy = 1'b0;
         end
         if (rst) begin
            m_busy   = 1'b0;
            exp_dout = '0;
         end
      end
   end

   logic [31:0] exp_addr  [4] = '{32'h8, 32'h8, 32'h9, 32'h9};
   logic [31:0] exp_wdata [4] = '{32'hBEEF, 32'hBEEF, 32'hDEAD, 32'hDEAD};
   logic [31:0] exp_we_n  [4] = '{32'h0, 32'h1, 32'h0, 32'h1};

   task automatic set_req(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      wr = w; rd = r; addr = a; din = d;
   endtask

   task automatic check_read_done(input string name, input logic [31:0] expect_word);
      for (int i = 0; i <= 2*W + 1; i++) begin
         @(negedge clk);
         chk({name, "_ready"}, 32'(ready), 32'(i == 2*W + 1));
         chk({name, "_we_n"}, 32'(we_n), 32'd1);
         if (i == 2*W + 1) chk({name, "_dout"}, dout, expect_word);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; mem_clr = 1'b1;
      rd = 0; wr = 0; addr = 0; din = 0;
      rd3 = 0; wr3 = 0; addr3 = 0; din3 = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0; mem_clr = 1'b0; chk_en = 1'b1;

      @(negedge clk);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_we_n", 32'(we_n), 32'd1);
      chk("rst_dout", dout, 32'd0);
      chk("rst_addr", 32'(saddr), 32'd0);

      set_req(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
      for (int i = 0; i <= 2*W + 1; i++) begin
         @(negedge clk);
         chk("wr_ready", 32'(ready), 32'(i == 2*W + 1));
         if (i >= 1 && i <= 2*W) begin
            chk("wr_addr", 32'(saddr), exp_addr[i-1]);
            chk("wr_wdata", 32'(swdata), exp_wdata[i-1]);
            chk("wr_we_n", 32'(we_n), exp_we_n[i-1]);
         end
      end

      set_req(1'b0, 1'b1, 32'h10, 32'h0);
      check_read_done("rd", 32'hDEADBEEF);

      set_req(1'b1, 1'b1, 32'h20, 32'h12345678);
      repeat (2*W + 2) @(negedge clk);
      chk("both_dout_kept", dout, 32'hDEADBEEF);
      chk("both_sram_lo", 32'(smem[16]), 32'h5678);
      chk("both_sram_hi", 32'(smem[17]), 32'h1234);
      set_req(1'b0, 1'b1, 32'h20, 32'h0);
      check_read_done("both_rd", 32'h12345678);

      set_req(1'b0, 1'b1, 32'h10, 32'h0);
      repeat (W + 1) @(posedge clk);
      #1;
      rst = 1'b1; rd = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_ready", 32'(ready), 32'd1);
      chk("midrst_dout", dout, 32'd0);
      chk("midrst_we_n", 32'(we_n), 32'd1);
      set_req(1'b0, 1'b1, 32'h10, 32'h0);
      check_read_done("postrst_rd", 32'hDEADBEEF);
      set_req(1'b0, 1'b0, 32'h0, 32'h0);

      @(posedge clk);
      #1;
      wr3 = 1'b1; rd3 = 1'b0; addr3 = 32'h40; din3 = 32'hCAFEF00D;
      for (int i = 0; i <= 15; i++) begin
         @(negedge clk);
         chk("w3_ready", 32'(ready3), 32'(i == 7 || i == 15));
         if (i >= 1 && i <= 6) chk("w3_we_n", 32'(we_n3), 32'((i % 3) == 0));
         if (i == 15) chk("w3_rdback", dout3, 32'hCAFEF00D);
         if (i == 7) begin
            @(posedge clk);
            #1;
            wr3 = 1'b0; rd3 = 1'b1;
         end
      end
      rd3 = 1'b0;

      for (int n = 0; n < 300; n++) begin
         int r;
         int k;
         logic [31:0] a;
         logic [31:0] d;
         r = $urandom_range(0, 15);
         a = $urandom();
         a[AW:2] = '0;
         a[5:2] = 4'($urandom_range(0, 15));
         d = $urandom();
         if (r >= 14) begin
            k = $urandom_range(0, 2*W);
            set_req(1'b0, 1'b1, a, d);
            repeat (k) @(posedge clk);
            #1;
            rst = 1'b1; rd = 1'b0; wr = 1'b0;
            @(posedge clk);
            #1;
            rst = 1'b0;
         end else begin
            set_req(r < 6 || r >= 12, r >= 6, a, d);
            if ($urandom_range(0, 7) == 0) begin
               @(posedge clk);
               #1;
               wr = 1'b0; rd = 1'b0; addr = $urandom(); din = $urandom();
               repeat (2*W) @(posedge clk);
            end else begin
               repeat (2*W + 1) @(posedge clk);
            end
         end
         repeat ($urandom_range(0, 2)) set_req(1'b0, 1'b0, $urandom(), $urandom());
      end

      repeat (3) set_req(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle initiator between the MEM pipeline stage and an external 16-bit-wide SRAM. Accepts the same single-word read/write request the on-chip data memory accepts: mem_read_in, mem_write_in, 32-bit address and data. Each 32-bit word is split into two 16-bit SRAM accesses, each stretched over a programmable number of wait cycles. `ready_out` is low while an access is in flight; the pipeline uses its inverse as the freeze signal.

## Interface
- `WAIT_CYCLES`, 2: cycles per 16-bit phase; legal range is 2 or more.
- `SRAM_ADDR_W`, 18: SRAM halfword-address width.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `mem_read_in` input 1: read request; held stable by the pipeline while `ready_out`=0.
- `mem_write_in` input 1: write request; held stable by the pipeline while `ready_out`=0.
- `address_in` input 32: byte address; the word index is `address_in[SRAM_ADDR_W:2]`.
- `data_in` input 32: write data.
- `data_out` output 32: last word read; registered.
- `ready_out` output 1: high when the requester may advance.
- `sram_addr_out` output SRAM_ADDR_W: SRAM halfword address.
- `sram_wdata_out` output 16: SRAM write data.
- `sram_rdata_in` input 16: SRAM read data, valid in the last cycle of a read phase.
- `sram_we_n_out` output 1: SRAM write enable, active-low.

## Operation
- States:
  - IDLE: no access in flight.
  - LOW: low-half phase.
  - HIGH: high-half phase.
  - DONE: single completion cycle.
- Wait counter: counts 0..WAIT_CYCLES-1 inside LOW and HIGH; cleared on every phase entry.
- IDLE:
  - With mem_write_in or mem_read_in = 1, latch the op (write wins if both are 1), word index and data_in, then go to LOW.
  - With neither, stay in IDLE.
- LOW:
  - `sram_addr_out` = {word, 1'b0}; `sram_wdata_out` = data[15:0].
  - Leave for HIGH when counter = WAIT_CYCLES-1.
- HIGH:
  - `sram_addr_out` = {word, 1'b1}; `sram_wdata_out` = data[31:16].
  - Leave for DONE when counter = WAIT_CYCLES-1.
- DONE: unconditionally go to IDLE next cycle. The request is not re-sampled in DONE.
- Write: `sram_we_n_out` = 0 during cycles 0..WAIT_CYCLES-2 of each phase and 1 in the last cycle. This gives address/data hold; the address never changes while we_n = 0.
- Read:
  - `sram_we_n_out` = 1 throughout.
  - `sram_rdata_in` is captured on the last cycle of LOW into `data_out[15:0]` and of HIGH into `data_out[31:16]`.
  - `data_out` is held until the next read; writes never modify it.
- `ready_out` (combinational from state and request):
  - 1 in DONE.
  - 1 in IDLE with no request.
  - 0 otherwise, including IDLE with a request present.
- Address bits above SRAM_ADDR_W and `address_in[1:0]` are ignored; no alignment check.

## Timing
- Reset values: state IDLE, counter 0, `data_out` 0, `sram_addr_out` 0, `sram_wdata_out` 0, `sram_we_n_out` 1. `ready_out` = 1 when no request is present.
- Request first seen in IDLE at cycle 0:
  - LOW occupies cycles 1..W.
  - HIGH occupies cycles W+1..2W.
  - DONE is cycle 2W+1.
  - `ready_out` is low for cycles 0..2W and high at 2W+1, so total latency is 2W+2 cycles (6 at W=2).
- Read data is fully valid in `data_out` at DONE, i.e. cycle 2W+1.
- Back-to-back requests: the request present in the cycle after DONE starts a new access. The IDLE-with-request cycle counts as cycle 0.
- Reset mid-access (any state, any counter): next cycle is IDLE with all reset values.
  - A partial write may remain in the SRAM.
  - `data_out` is cleared.
- Simultaneous read and write: treated as a write; `data_out` is unchanged.
- Request withdrawn mid-access (protocol violation): the access completes anyway using the latched values.

## Test plan
- After reset with no request: `ready_out`=1, `sram_we_n_out`=1, `data_out`=0, `sram_addr_out`=0.
- Write 0xDEADBEEF to byte address 0x10, W=2:
  - `ready_out` is 0 for 5 cycles, then 1.
  - Addr 0x8 with wdata 0xBEEF, we_n pattern 0,1.
  - Then addr 0x9 with wdata 0xDEAD, we_n pattern 0,1.
- Read byte address 0x10 with an SRAM model holding 0xBEEF at 0x8 and 0xDEAD at 0x9: `data_out`=0xDEADBEEF at the cycle `ready_out` rises; we_n stays 1 throughout.
- Back-to-back write then read of the same address, W=3: `ready_out` rises at cycle 7 and again 8 cycles later; the read returns the written word.
- Both mem_read_in and mem_write_in asserted with data_in=0x12345678: the SRAM receives the write; `data_out` keeps its prior value.
- `rst` pulsed in HIGH of a read: next cycle state IDLE, `data_out`=0, we_n=1. A fresh read then completes normally in 2W+2 cycles.
